// File: rtl/demux_1_to_4_tdm_pkg.sv
// demux_1_to_4_tdm_pkg
// Shared definitions for the TDM 1-to-4 demultiplexer:
//   state_t        - frame-alignment FSM states (HUNT / LOCKED)
//   SLOT_A..SLOT_D - slot numbers, matching the transmit-side {s1,s2} mapping
package demux_1_to_4_tdm_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr
// 2-bit slot counter tracking the expected next slot of the TDM stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to slot 0 (highest priority)
//   load       : synchronous load to slot 1 (a sync sample was taken as slot 0)
//   en         : increment mod 4 (an in-sequence sample was accepted)
//   slot       : expected next slot, {s1,s2}
module demux_slot_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  logic       en,
  output logic [1:0] slot
);

  import demux_1_to_4_tdm_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_A;
    end else if (clear) begin
      slot <= SLOT_A;
    end else if (load) begin
      slot <= SLOT_B;
    end else if (en) begin
      slot <= slot + 2'd1;
    end
  end

endmodule

// File: rtl/demux_1_to_4_tdm.sv
// demux_1_to_4_tdm
// Receive-side TDM demultiplexer: splits a serial stream of four interleaved
// channels (slot 0 flagged by sync) into four parallel registered outputs.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   din          : serial sample (WIDTH bits)
//   din_valid    : din holds a sample this cycle
//   sync         : current sample is slot 0 (qualified by din_valid)
//   a, b, c, d   : slots 0..3 of the last complete frame
//   out_valid    : one-cycle pulse when a..d update
//   s1, s2       : expected next slot {s1,s2}
//   locked       : frame alignment held
//   frame_err    : one-cycle pulse on an alignment violation
module demux_1_to_4_tdm #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic             s1,
  output logic             s2,
  output logic             locked,
  output logic             frame_err
);

  import demux_1_to_4_tdm_pkg::*;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] stage_a;
  logic [WIDTH-1:0] stage_b;
  logic [WIDTH-1:0] stage_c;
  logic             ctr_clear;
  logic             ctr_load;
  logic             ctr_en;

  // Any accepted sync sample starts a frame, so the next slot is always 1;
  // a missing sync at slot 0 while locked drops back to slot 0.
  always_comb begin
    ctr_clear = 1'b0;
    ctr_load  = 1'b0;
    ctr_en    = 1'b0;
    if (din_valid) begin
      if (state == ST_LOCKED && slot == SLOT_A && !sync) begin
        ctr_clear = 1'b1;
      end else if (sync) begin
        ctr_load = 1'b1;
      end else if (state == ST_LOCKED) begin
        ctr_en = 1'b1;
      end
    end
  end

  demux_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ctr_clear),
    .load  (ctr_load),
    .en    (ctr_en),
    .slot  (slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      stage_a   <= '0;
      stage_b   <= '0;
      stage_c   <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      if (din_valid) begin
        case (state)
          ST_HUNT: begin
            if (sync) begin
              stage_a <= din;
              state   <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (slot == SLOT_A && !sync) begin
              frame_err <= 1'b1;
              stage_a   <= '0;
              stage_b   <= '0;
              stage_c   <= '0;
              state     <= ST_HUNT;
            end else if (slot != SLOT_A && sync) begin
              // Restart the frame on the early sync; stale slots are cleared.
              frame_err <= 1'b1;
              stage_a   <= din;
              stage_b   <= '0;
              stage_c   <= '0;
            end else begin
              case (slot)
                SLOT_A: stage_a <= din;
                SLOT_B: stage_b <= din;
                SLOT_C: stage_c <= din;
                SLOT_D: begin
                  a         <= stage_a;
                  b         <= stage_b;
                  c         <= stage_c;
                  d         <= din;
                  out_valid <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign s1     = slot[1];
  assign s2     = slot[0];

endmodule

// File: tb/tb_demux_1_to_4_tdm.sv
// tb_demux_1_to_4_tdm
// Directed self-checking bench for demux_1_to_4_tdm (WIDTH=8).
module tb_demux_1_to_4_tdm;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       sync;
  logic [7:0] a, b, c, d;
  logic       out_valid;
  logic       s1, s2;
  logic       locked;
  logic       frame_err;

  int checks;
  int errors;
  int cyc;
  int ov_count;
  int ov_cycle;
  int base;
  int t1;

  demux_1_to_4_tdm #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .sync      (sync),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .s1        (s1),
    .s2        (s2),
    .locked    (locked),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled at the same point.
  task automatic step(input logic v, input logic s, input logic [7:0] x);
    din_valid = v;
    sync      = s;
    din       = x;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      ov_count++;
      ov_cycle = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ov_count = 0; ov_cycle = 0;
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {a, b, c, d}, 32'h0);
    check("rst_flags", {28'h0, out_valid, frame_err, locked, s1}, 32'h0);
    check("rst_slot", {31'h0, s2}, 32'h0);
    rst_n = 1'b1;

    // 1: aligned frame
    step(1, 1, 8'h11);
    check("t1_locked", {30'h0, locked, out_valid}, 32'h2);
    check("t1_slot1", {30'h0, s1, s2}, 32'h1);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    check("t1_slot3", {29'h0, s1, s2, out_valid}, 32'h6);
    step(1, 0, 8'h44);
    check("t1_ov", {31'h0, out_valid}, 32'h1);
    check("t1_data", {a, b, c, d}, 32'h11223344);
    check("t1_wrap", {30'h0, s1, s2}, 32'h0);
    idle(1);
    check("t1_ov_drop", {31'h0, out_valid}, 32'h0);

    // 2: same frame with 2-cycle gaps
    base = ov_count;
    step(1, 1, 8'h11); idle(2);
    check("t2_hold1", {30'h0, s1, s2}, 32'h1);
    step(1, 0, 8'h22); idle(2);
    check("t2_hold2", {30'h0, s1, s2}, 32'h2);
    step(1, 0, 8'h33); idle(2);
    check("t2_hold3", {30'h0, s1, s2}, 32'h3);
    step(1, 0, 8'h44); idle(2);
    check("t2_ov_once", ov_count - base, 1);
    check("t2_data", {a, b, c, d}, 32'h11223344);

    // 3: early sync restarts the frame
    base = ov_count;
    step(1, 1, 8'h11);
    step(1, 0, 8'h22);
    step(1, 1, 8'h55);
    check("t3_err", {30'h0, frame_err, locked}, 32'h3);
    check("t3_slot", {30'h0, s1, s2}, 32'h1);
    step(1, 0, 8'h66);
    check("t3_err_pulse", {31'h0, frame_err}, 32'h0);
    step(1, 0, 8'h77);
    step(1, 0, 8'h88);
    check("t3_ov_once", ov_count - base, 1);
    check("t3_data", {a, b, c, d}, 32'h55667788);

    // 4: missing sync at slot 0
    step(1, 0, 8'h99);
    check("t4_err", {30'h0, frame_err, locked}, 32'h2);
    check("t4_hold", {a, b, c, d}, 32'h55667788);
    base = ov_count;
    step(1, 0, 8'h12);
    step(1, 0, 8'h13);
    step(1, 0, 8'h14);
    step(1, 0, 8'h15);
    check("t4_hunt", {29'h0, locked, s1, s2, frame_err}, 32'h0);
    check("t4_no_ov", ov_count - base, 0);
    step(1, 1, 8'h21);
    check("t4_relock", {31'h0, locked}, 32'h1);
    step(1, 0, 8'h22);
    step(1, 0, 8'h23);
    step(1, 0, 8'h24);
    check("t4_data", {a, b, c, d}, 32'h21222324);

    // 5: HUNT drop then back-to-back frames
    rst_n = 1'b0; #1; rst_n = 1'b1;
    base = ov_count;
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    check("t5_drop", ov_count - base, 0);
    check("t5_unlocked", {31'h0, locked}, 32'h0);
    step(1, 1, 8'hB1); step(1, 0, 8'hB2); step(1, 0, 8'hB3); step(1, 0, 8'hB4);
    check("t5_f1", {a, b, c, d}, 32'hB1B2B3B4);
    t1 = ov_cycle;
    step(1, 1, 8'hC1); step(1, 0, 8'hC2); step(1, 0, 8'hC3); step(1, 0, 8'hC4);
    check("t5_f2", {a, b, c, d}, 32'hC1C2C3C4);
    check("t5_spacing", ov_cycle - t1, 4);
    check("t5_ov_count", ov_count - base, 2);

    // 6: asynchronous reset mid-frame
    step(1, 1, 8'h31);
    step(1, 0, 8'h32);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", {a, b, c, d}, 32'h0);
    check("t6_rst_flags", {28'h0, locked, s1, s2, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = ov_count;
    step(1, 0, 8'h33);
    step(1, 0, 8'h34);
    check("t6_no_ov", ov_count - base, 0);
    check("t6_unlocked", {31'h0, locked}, 32'h0);
    step(1, 1, 8'h51); step(1, 0, 8'h52); step(1, 0, 8'h53);
    check("t6_no_ov_yet", ov_count - base, 0);
    step(1, 0, 8'h54);
    check("t6_ov", {31'h0, out_valid}, 32'h1);
    check("t6_data", {a, b, c, d}, 32'h51525354);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
